// File: rtl/wb8_bus_pkg.sv
// Shared constants and types for the 8-bit Wishbone interconnect.
// Used by the decoder top and its testbench.
package wb8_bus_pkg;

    localparam int         NSLAVES  = 4;
    localparam logic [7:0] ERR_DATA = 8'hFF;

    // Encoded as plain constants so legacy tooling can compare raw state bits.
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_ACK = 2'd1;
    localparam logic [1:0] ERR_ACK  = 2'd2;

    typedef logic [1:0] slave_idx_t;

endpackage

// File: rtl/wb8_bus_if.sv
// Master-side Wishbone-B4 pipelined 8-bit bus between the CPU adapter and the decoder.
interface wb8_bus_if;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [7:0]  dat_w;
    logic [7:0]  dat_r;
    logic        ack;
    logic        stall;

    modport master (
        output cyc, stb, we, adr, dat_w,
        input  dat_r, ack, stall
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w,
        output dat_r, ack, stall
    );

endinterface

// File: rtl/wb8_watchdog.sv
// Saturating 8-bit cycle counter that flags a transfer which has waited TIMEOUT cycles.
module wb8_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
        if (!rst_n) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    assign expire = enable && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/wb8_bus_decoder.sv
// Single-master, four-slave 8-bit Wishbone interconnect with one outstanding transfer
// and a watchdog that converts a hung transfer into an error-ACK.
module wb8_bus_decoder
    import wb8_bus_pkg::*;
#(
    parameter logic [3:0] REGION1 = 4'hF,
    parameter logic [3:0] REGION2 = 4'hE,
    parameter logic [3:0] REGION3 = 4'hD,
    parameter int         TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    wb8_bus_if.slave               wb,
    output logic [NSLAVES-1:0]     s_stb,
    input  logic [NSLAVES-1:0]     s_ack,
    input  logic [NSLAVES-1:0]     s_stall,
    input  logic [8*NSLAVES-1:0]   s_dat,
    output logic                   err,
    output logic [31:0]            err_adr
);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    slave_idx_t  sel_d;
    slave_idx_t  sel_q;
    logic [31:0] adr_q;
    logic        req;
    logic        accept;
    logic        sel_ack;
    logic        wd_expire;
    logic        unused_bus;

    // WE and write data reach the slaves directly from the master wires.
    assign unused_bus = ^{wb.we, wb.dat_w};

    always_comb begin
        if (wb.adr[31:28] == REGION1) begin
            sel_d = 2'd1;
        end else if (wb.adr[31:28] == REGION2) begin
            sel_d = 2'd2;
        end else if (wb.adr[31:28] == REGION3) begin
            sel_d = 2'd3;
        end else begin
            sel_d = 2'd0;
        end
    end

    assign req     = wb.cyc & wb.stb;
    assign accept  = (state == IDLE) & req & ~s_stall[sel_d];
    assign sel_ack = s_ack[sel_q];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        s_stb     = '0;
        wb.stall  = 1'b1;
        wb.ack    = 1'b0;
        wb.dat_r  = 8'h00;
        err       = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                s_stb[sel_d] = req;
                wb.stall     = s_stall[sel_d];
                if (accept) state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                wb.dat_r = s_dat[{sel_q, 3'b000} +: 8];
                // An aborting master gets no ACK even if the slave answers in the same cycle.
                if (!wb.cyc) begin
                    state_nxt = IDLE;
                end else if (sel_ack) begin
                    wb.ack    = 1'b1;
                    state_nxt = IDLE;
                end else if (wd_expire) begin
                    state_nxt = ERR_ACK;
                end
            end
            ERR_ACK: begin
                wb.ack    = 1'b1;
                wb.dat_r  = ERR_DATA;
                err       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel_q   <= '0;
            adr_q   <= '0;
            err_adr <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                sel_q <= sel_d;
                adr_q <= wb.adr;
            end
            if (state == ERR_ACK) err_adr <= adr_q;
        end
    end

    wb8_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != WAIT_ACK),
        .enable (state == WAIT_ACK),
        .expire (wd_expire)
    );

endmodule

// File: tb/tb_wb8_bus_decoder.sv
// Directed bench for wb8_bus_decoder: decode, ACK routing, stall, watchdog, abort and reset.
module tb_wb8_bus_decoder;

    localparam int TO = 8;

    logic        clk;
    logic        rst_n;
    logic [3:0]  s_stb;
    logic [3:0]  s_ack;
    logic [3:0]  s_stall;
    logic [31:0] s_dat;
    logic        err;
    logic [31:0] err_adr;

    int checks;
    int failures;

    wb8_bus_if bus ();

    wb8_bus_decoder #(
        .REGION1 (4'hF),
        .REGION2 (4'hE),
        .REGION3 (4'hD),
        .TIMEOUT (TO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wb      (bus),
        .s_stb   (s_stb),
        .s_ack   (s_ack),
        .s_stall (s_stall),
        .s_dat   (s_dat),
        .err     (err),
        .err_adr (err_adr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.cyc = 1'b0;  bus.stb = 1'b0;  bus.we = 1'b0;
        bus.adr = 32'h0; bus.dat_w = 8'h00;
        s_ack   = 4'b0;  s_stall = 4'b0;  s_dat = 32'h0;
        #2;
        checks++;
        if (bus.ack !== 1'b0 || s_stb !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ack_stb: ack=%b s_stb=%b want 0/0000", bus.ack, s_stb);
        end
        checks++;
        if (err !== 1'b0 || err_adr !== 32'h0) begin
            failures++;
            $display("FAIL reset_err: err=%b err_adr=%h want 0/00000000", err, err_adr);
        end
        checks++;
        if (bus.dat_r !== 8'h00) begin
            failures++;
            $display("FAIL reset_dat: got %h want 00", bus.dat_r);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_read_ram();
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 32'h0000_0010;
        @(negedge clk);
        checks++;
        if (s_stb !== 4'b0001 || bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL t1_strobe: s_stb=%b stall=%b want 0001/0", s_stb, bus.stall);
        end
        step();
        bus.stb = 1'b0;
        @(negedge clk);
        checks++;
        if (s_stb !== 4'b0000 || bus.stall !== 1'b1 || bus.ack !== 1'b0) begin
            failures++;
            $display("FAIL t1_wait: s_stb=%b stall=%b ack=%b want 0000/1/0", s_stb, bus.stall, bus.ack);
        end
        step();
        s_ack = 4'b0001; s_dat = 32'h0000_005A;
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b1 || bus.dat_r !== 8'h5A) begin
            failures++;
            $display("FAIL t1_ack: ack=%b dat=%h want 1/5a", bus.ack, bus.dat_r);
        end
        step();
        s_ack = 4'b0000; bus.cyc = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b0 || bus.dat_r !== 8'h00) begin
            failures++;
            $display("FAIL t1_after: ack=%b dat=%h want 0/00", bus.ack, bus.dat_r);
        end
        step();
    endtask

    task automatic test_write_led();
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1;
        bus.adr = 32'hF000_0000; bus.dat_w = 8'hF0;
        @(negedge clk);
        checks++;
        if (s_stb !== 4'b0010) begin
            failures++;
            $display("FAIL t2_strobe: s_stb=%b want 0010", s_stb);
        end
        step();
        bus.stb = 1'b0; bus.we = 1'b0;
        s_ack = 4'b0001; s_dat = 32'h0000_00AA;
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b0) begin
            failures++;
            $display("FAIL t2_foreign_ack: ack=%b want 0", bus.ack);
        end
        step();
        s_ack = 4'b0010;
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b1 || s_stb !== 4'b0000) begin
            failures++;
            $display("FAIL t2_ack: ack=%b s_stb=%b want 1/0000", bus.ack, s_stb);
        end
        step();
        s_ack = 4'b0000; bus.cyc = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b0) begin
            failures++;
            $display("FAIL t2_after: ack=%b want 0", bus.ack);
        end
        step();
    endtask

    task automatic test_back_to_back();
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.adr = 32'hE000_0004;
        @(negedge clk);
        checks++;
        if (s_stb !== 4'b0100) begin
            failures++;
            $display("FAIL b2b_strobe_e: s_stb=%b want 0100", s_stb);
        end
        step();
        bus.adr = 32'hD000_0008; s_ack = 4'b0100; s_dat = 32'h0099_0000;
        @(negedge clk);
        checks++;
        if (s_stb !== 4'b0000 || bus.ack !== 1'b1 || bus.dat_r !== 8'h99) begin
            failures++;
            $display("FAIL b2b_ack_e: s_stb=%b ack=%b dat=%h want 0000/1/99", s_stb, bus.ack, bus.dat_r);
        end
        step();
        s_ack = 4'b0000;
        @(negedge clk);
        checks++;
        if (s_stb !== 4'b1000 || bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL b2b_strobe_d: s_stb=%b stall=%b want 1000/0", s_stb, bus.stall);
        end
        step();
        bus.stb = 1'b0; s_ack = 4'b1000; s_dat = 32'h3C00_0000;
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b1 || bus.dat_r !== 8'h3C) begin
            failures++;
            $display("FAIL b2b_ack_d: ack=%b dat=%h want 1/3c", bus.ack, bus.dat_r);
        end
        step();
        s_ack = 4'b0000; bus.cyc = 1'b0;
        step();
    endtask

    task automatic test_stall();
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.adr = 32'h0000_0020; s_stall = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.stall !== 1'b1 || s_stb !== 4'b0001) begin
                failures++;
                $display("FAIL t3_stalled[%0d]: stall=%b s_stb=%b want 1/0001", i, bus.stall, s_stb);
            end
            step();
        end
        s_stall = 4'b0000;
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0 || s_stb !== 4'b0001) begin
            failures++;
            $display("FAIL t3_release: stall=%b s_stb=%b want 0/0001", bus.stall, s_stb);
        end
        step();
        bus.stb = 1'b0;
        @(negedge clk);
        checks++;
        if (s_stb !== 4'b0000 || bus.stall !== 1'b1) begin
            failures++;
            $display("FAIL t3_accepted: s_stb=%b stall=%b want 0000/1", s_stb, bus.stall);
        end
        step();
        s_ack = 4'b0001; s_dat = 32'h0000_0011;
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b1 || bus.dat_r !== 8'h11) begin
            failures++;
            $display("FAIL t3_ack: ack=%b dat=%h want 1/11", bus.ack, bus.dat_r);
        end
        step();
        s_ack = 4'b0000; bus.cyc = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.adr = 32'hD000_1234; s_dat = 32'h5500_0000;
        @(negedge clk);
        checks++;
        if (s_stb !== 4'b1000) begin
            failures++;
            $display("FAIL t4_strobe: s_stb=%b want 1000", s_stb);
        end
        step();
        bus.stb = 1'b0;
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            checks++;
            if (bus.ack !== 1'b0 || err !== 1'b0) begin
                failures++;
                $display("FAIL t4_wait[%0d]: ack=%b err=%b want 0/0", i, bus.ack, err);
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b1 || bus.dat_r !== 8'hFF || err !== 1'b1 || bus.stall !== 1'b1) begin
            failures++;
            $display("FAIL t4_err_ack: ack=%b dat=%h err=%b stall=%b want 1/ff/1/1",
                     bus.ack, bus.dat_r, err, bus.stall);
        end
        step();
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || bus.ack !== 1'b0 || err_adr !== 32'hD000_1234) begin
            failures++;
            $display("FAIL t4_after: err=%b ack=%b err_adr=%h want 0/0/d0001234", err, bus.ack, err_adr);
        end
        step();
        s_ack = 4'b1000;
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b0 || err_adr !== 32'hD000_1234) begin
            failures++;
            $display("FAIL t4_late_ack: ack=%b err_adr=%h want 0/d0001234", bus.ack, err_adr);
        end
        step();
        s_ack = 4'b0000; bus.cyc = 1'b0;
        step();
    endtask

    task automatic test_abort();
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.adr = 32'h0000_0030; s_dat = 32'h0;
        step();
        bus.stb = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b1 || bus.ack !== 1'b0) begin
            failures++;
            $display("FAIL t5_wait: stall=%b ack=%b want 1/0", bus.stall, bus.ack);
        end
        step();
        bus.cyc = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b0) begin
            failures++;
            $display("FAIL t5_abort_ack: ack=%b want 0", bus.ack);
        end
        step();
        s_ack = 4'b0001;
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b0 || bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL t5_idle: ack=%b stall=%b want 0/0", bus.ack, bus.stall);
        end
        step();
        s_ack = 4'b0000;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.adr = 32'h0000_0040;
        @(negedge clk);
        checks++;
        if (s_stb !== 4'b0001) begin
            failures++;
            $display("FAIL t5_restrobe: s_stb=%b want 0001", s_stb);
        end
        step();
        bus.stb = 1'b0; s_ack = 4'b0001; s_dat = 32'h0000_0077;
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b1 || bus.dat_r !== 8'h77) begin
            failures++;
            $display("FAIL t5_read: ack=%b dat=%h want 1/77", bus.ack, bus.dat_r);
        end
        step();
        s_ack = 4'b0000; bus.cyc = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.adr = 32'hE000_0000; s_dat = 32'h0066_0000;
        step();
        bus.stb = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b1 || err_adr !== 32'hD000_1234) begin
            failures++;
            $display("FAIL t6_pre: stall=%b err_adr=%h want 1/d0001234", bus.stall, err_adr);
        end
        #2;
        rst_n = 1'b0;
        s_ack = 4'b0100;
        #1;
        checks++;
        if (bus.ack !== 1'b0 || bus.stall !== 1'b0 || s_stb !== 4'b0000) begin
            failures++;
            $display("FAIL t6_async: ack=%b stall=%b s_stb=%b want 0/0/0000", bus.ack, bus.stall, s_stb);
        end
        checks++;
        if (err_adr !== 32'h0 || err !== 1'b0 || bus.dat_r !== 8'h00) begin
            failures++;
            $display("FAIL t6_regs: err_adr=%h err=%b dat=%h want 00000000/0/00", err_adr, err, bus.dat_r);
        end
        s_ack = 4'b0000; bus.cyc = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_read_ram();
        test_write_led();
        test_back_to_back();
        test_stall();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
